// File: rtl/eflags_pkg.sv
// Shared constants for the EFLAGS write-back path: flag bit positions,
// writable-bit mask, controller state encoding and mask widening helper.
package eflags_pkg;

   localparam int unsigned FLAGS_W = 32;
   localparam int unsigned MASK_W  = 12;

   localparam int unsigned CF_BIT = 0;
   localparam int unsigned PF_BIT = 2;
   localparam int unsigned AF_BIT = 4;
   localparam int unsigned ZF_BIT = 6;
   localparam int unsigned SF_BIT = 7;
   localparam int unsigned DF_BIT = 10;
   localparam int unsigned OF_BIT = 11;

   // Bits 0,2,4,6,7,10,11 are architecturally writable; the rest read as zero
   localparam logic [MASK_W-1:0] WR_MASK = 12'hCD5;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_SYS_WR = 2'd2
   } wb_state_e;

   // Restrict a port mask to writable bits and zero-extend to the flag width
   function automatic logic [FLAGS_W-1:0] eff_mask(input logic [MASK_W-1:0] m);
      return FLAGS_W'(m & WR_MASK);
   endfunction

endpackage

// File: rtl/eflags_merge.sv
// Combinational masked merge of a new flag word into the current one.
module eflags_merge
   import eflags_pkg::*;
(
   input  logic [FLAGS_W-1:0] old_flags,
   input  logic [FLAGS_W-1:0] new_flags,
   input  logic [MASK_W-1:0]  mask,
   output logic [FLAGS_W-1:0] next_flags
);

   logic [FLAGS_W-1:0] m;

   always_comb begin
      m          = eff_mask(mask);
      next_flags = (old_flags & ~m) | (new_flags & m);
   end

endmodule

// File: rtl/eflags_wb_ctrl.sv
// Architectural EFLAGS register with EX / system-port write arbitration,
// per-flag write masking and an in-flight flag-writer counter.
module eflags_wb_ctrl
   import eflags_pkg::*;
#(
   parameter int unsigned       PEND_W      = 3,
   parameter logic [FLAGS_W-1:0] RESET_FLAGS = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               issue_inc,
   output logic               issue_ready,
   input  logic               ex_valid,
   output logic               ex_ready,
   input  logic [FLAGS_W-1:0] ex_flags,
   input  logic [MASK_W-1:0]  ex_mask,
   input  logic               sys_valid,
   output logic               sys_ready,
   input  logic [FLAGS_W-1:0] sys_flags,
   input  logic [MASK_W-1:0]  sys_mask,
   output logic [FLAGS_W-1:0] flags_q,
   output logic               flags_stall,
   output logic               pend_err
);

   localparam logic [PEND_W-1:0] PEND_MAX  = '1;
   localparam logic [PEND_W-1:0] PEND_ZERO = '0;
   localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
   localparam logic [FLAGS_W-1:0] RESET_VAL = RESET_FLAGS & eff_mask(WR_MASK);

   wb_state_e          state_q, state_d;
   logic [PEND_W-1:0]  pend_q, pend_d;
   logic               pend_err_d;
   logic               ex_xfer;
   logic               sys_acc;
   logic               inc_acc;
   logic [FLAGS_W-1:0] ex_next;
   logic [FLAGS_W-1:0] sys_next;
   logic [FLAGS_W-1:0] flags_d;

   eflags_merge u_ex_merge (
      .old_flags  (flags_q),
      .new_flags  (ex_flags),
      .mask       (ex_mask),
      .next_flags (ex_next)
   );

   eflags_merge u_sys_merge (
      .old_flags  (flags_q),
      .new_flags  (sys_flags),
      .mask       (sys_mask),
      .next_flags (sys_next)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and handshake outputs; EX always wins, sys waits for an empty pipe
   always_comb begin
      state_d     = state_q;
      ex_ready    = 1'b1;
      sys_ready   = 1'b0;
      issue_ready = 1'b0;
      ex_xfer     = 1'b0;
      sys_acc     = 1'b0;
      case (state_q)
         ST_RUN: begin
            ex_xfer     = ex_valid;
            issue_ready = (pend_q != PEND_MAX) | ex_valid;
            if (sys_valid && !ex_valid) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            ex_xfer = ex_valid;
            if (!sys_valid) begin
               state_d = ST_RUN;
            end else if ((pend_q == PEND_ZERO) && !ex_valid) begin
               state_d = ST_SYS_WR;
            end
         end
         ST_SYS_WR: begin
            ex_ready  = 1'b0;
            sys_ready = 1'b1;
            sys_acc   = sys_valid;
            state_d   = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // Pending-writer counter with sticky overflow/underflow detection
   always_comb begin
      pend_d     = pend_q;
      pend_err_d = pend_err;
      inc_acc    = issue_inc & issue_ready;
      if (issue_inc && !issue_ready) begin
         pend_err_d = 1'b1;
      end
      if (inc_acc && !ex_xfer) begin
         pend_d = pend_q + PEND_ONE;
      end else if (!inc_acc && ex_xfer) begin
         if (pend_q == PEND_ZERO) begin
            pend_err_d = 1'b1;
         end else begin
            pend_d = pend_q - PEND_ONE;
         end
      end
   end

   // Flag write-back select
   always_comb begin
      flags_d = flags_q;
      if (ex_xfer) begin
         flags_d = ex_next;
      end else if (sys_acc) begin
         flags_d = sys_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend_q      <= PEND_ZERO;
         pend_err    <= 1'b0;
         flags_stall <= 1'b0;
         flags_q     <= RESET_VAL;
      end else begin
         pend_q      <= pend_d;
         pend_err    <= pend_err_d;
         flags_stall <= (pend_d != PEND_ZERO);
         flags_q     <= flags_d;
      end
   end

endmodule

// File: tb/tb_eflags_wb_ctrl.sv
// Directed self-checking bench for eflags_wb_ctrl.
module tb_eflags_wb_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        issue_inc;
   logic        issue_ready;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_flags;
   logic [11:0] ex_mask;
   logic        sys_valid;
   logic        sys_ready;
   logic [31:0] sys_flags;
   logic [11:0] sys_mask;
   logic [31:0] flags_q;
   logic        flags_stall;
   logic        pend_err;

   int errors = 0;
   int checks = 0;

   eflags_wb_ctrl #(.PEND_W(3), .RESET_FLAGS(32'h0000_0000)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .issue_inc   (issue_inc),
      .issue_ready (issue_ready),
      .ex_valid    (ex_valid),
      .ex_ready    (ex_ready),
      .ex_flags    (ex_flags),
      .ex_mask     (ex_mask),
      .sys_valid   (sys_valid),
      .sys_ready   (sys_ready),
      .sys_flags   (sys_flags),
      .sys_mask    (sys_mask),
      .flags_q     (flags_q),
      .flags_stall (flags_stall),
      .pend_err    (pend_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; issue_inc = 1'b1; ex_valid = 1'b1;
      ex_flags = 32'hFFFF_FFFF; ex_mask = 12'hFFF;
      sys_valid = 1'b0; sys_flags = 32'h0; sys_mask = 12'h0;
      tick(); tick();
      checks++; if (flags_q !== 32'h0) begin errors++; $display("FAIL reset_flags: got %h exp %h", flags_q, 32'h0); end
      checks++; if (flags_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b exp 0", flags_stall); end
      checks++; if (pend_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", pend_err); end
      ex_valid = 1'b0; issue_inc = 1'b0; rst_n = 1'b1;
      #1;
      checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_ex_ready: got %b exp 1", ex_ready); end
      checks++; if (sys_ready !== 1'b0) begin errors++; $display("FAIL reset_sys_ready: got %b exp 0", sys_ready); end
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready: got %b exp 1", issue_ready); end
   endtask

   task automatic test_ex_mask();
      logic [31:0] vf [4];
      logic [11:0] vm [4];
      logic [31:0] ve [4];
      vf[0] = 32'hFFFF_FFFF; vm[0] = 12'h0C1; ve[0] = 32'h0000_00C1;
      vf[1] = 32'hFFFF_FFFF; vm[1] = 12'hFFF; ve[1] = 32'h0000_0CD5;
      vf[2] = 32'h0000_0000; vm[2] = 12'h001; ve[2] = 32'h0000_0CD4;
      vf[3] = 32'h0000_0000; vm[3] = 12'hFFF; ve[3] = 32'h0000_0000;
      for (int i = 0; i < 4; i++) begin
         issue_inc = 1'b1; ex_valid = 1'b1; ex_flags = vf[i]; ex_mask = vm[i];
         tick();
         checks++; if (flags_q !== ve[i]) begin errors++; $display("FAIL ex_mask[%0d]: got %h exp %h", i, flags_q, ve[i]); end
      end
      issue_inc = 1'b0; ex_valid = 1'b0;
      checks++; if (flags_stall !== 1'b0) begin errors++; $display("FAIL ex_mask_stall: got %b exp 0", flags_stall); end
      checks++; if (pend_err !== 1'b0) begin errors++; $display("FAIL ex_mask_err: got %b exp 0", pend_err); end
   endtask

   task automatic test_serialise();
      issue_inc = 1'b1; tick(); tick(); issue_inc = 1'b0;
      checks++; if (flags_stall !== 1'b1) begin errors++; $display("FAIL ser_stall: got %b exp 1", flags_stall); end
      sys_valid = 1'b1; sys_flags = 32'h0000_0400; sys_mask = 12'h400;
      #1;
      checks++; if (sys_ready !== 1'b0) begin errors++; $display("FAIL ser_run_sys_ready: got %b exp 0", sys_ready); end
      tick();
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL ser_drain_issue_ready: got %b exp 0", issue_ready); end
      ex_valid = 1'b1; ex_flags = 32'h1; ex_mask = 12'h001;
      #1;
      checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL ser_drain_ex_ready: got %b exp 1", ex_ready); end
      tick();
      checks++; if (flags_q !== 32'h1) begin errors++; $display("FAIL ser_ex1: got %h exp %h", flags_q, 32'h1); end
      checks++; if (sys_ready !== 1'b0) begin errors++; $display("FAIL ser_pend1_sys_ready: got %b exp 0", sys_ready); end
      ex_mask = 12'h000;
      tick();
      ex_valid = 1'b0;
      #1;
      checks++; if (flags_stall !== 1'b0) begin errors++; $display("FAIL ser_drained_stall: got %b exp 0", flags_stall); end
      checks++; if (sys_ready !== 1'b0) begin errors++; $display("FAIL ser_drained_sys_ready: got %b exp 0", sys_ready); end
      tick();
      checks++; if (sys_ready !== 1'b1) begin errors++; $display("FAIL ser_sys_ready: got %b exp 1", sys_ready); end
      checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL ser_sys_ex_ready: got %b exp 0", ex_ready); end
      tick();
      sys_valid = 1'b0;
      checks++; if (flags_q !== 32'h401) begin errors++; $display("FAIL ser_df: got %h exp %h", flags_q, 32'h401); end
      checks++; if (sys_ready !== 1'b0) begin errors++; $display("FAIL ser_after_sys_ready: got %b exp 0", sys_ready); end
      checks++; if (pend_err !== 1'b0) begin errors++; $display("FAIL ser_err: got %b exp 0", pend_err); end
   endtask

   task automatic test_sys_latency();
      sys_valid = 1'b1; sys_flags = 32'h0; sys_mask = 12'h400;
      tick();
      checks++; if (sys_ready !== 1'b0) begin errors++; $display("FAIL lat_cycle1: got %b exp 0", sys_ready); end
      tick();
      checks++; if (sys_ready !== 1'b1) begin errors++; $display("FAIL lat_cycle2: got %b exp 1", sys_ready); end
      tick();
      sys_valid = 1'b0;
      checks++; if (flags_q !== 32'h001) begin errors++; $display("FAIL lat_df_clear: got %h exp %h", flags_q, 32'h001); end
      // request withdrawn during drain
      sys_valid = 1'b1; sys_flags = 32'h400; sys_mask = 12'h400;
      tick();
      sys_valid = 1'b0;
      #1;
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL drop_drain: got %b exp 0", issue_ready); end
      tick();
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL drop_run: got %b exp 1", issue_ready); end
      tick();
      checks++; if (flags_q !== 32'h001) begin errors++; $display("FAIL drop_nowrite: got %h exp %h", flags_q, 32'h001); end
   endtask

   task automatic test_collision();
      issue_inc = 1'b1; tick(); tick(); tick();
      ex_valid = 1'b1; ex_flags = 32'h80; ex_mask = 12'h080;
      #1;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL col_issue_ready: got %b exp 1", issue_ready); end
      tick();
      issue_inc = 1'b0; ex_mask = 12'h000;
      checks++; if (flags_q !== 32'h081) begin errors++; $display("FAIL col_sf: got %h exp %h", flags_q, 32'h081); end
      tick(); tick();
      checks++; if (flags_stall !== 1'b1) begin errors++; $display("FAIL col_pend1: got %b exp 1", flags_stall); end
      tick();
      ex_valid = 1'b0;
      checks++; if (flags_stall !== 1'b0) begin errors++; $display("FAIL col_pend0: got %b exp 0", flags_stall); end
      checks++; if (pend_err !== 1'b0) begin errors++; $display("FAIL col_err: got %b exp 0", pend_err); end
      // EX and sys together in RUN: EX first
      sys_valid = 1'b1; sys_flags = 32'h400; sys_mask = 12'h400;
      ex_valid = 1'b1; issue_inc = 1'b1; ex_flags = 32'h800; ex_mask = 12'h800;
      #1;
      checks++; if (sys_ready !== 1'b0) begin errors++; $display("FAIL col_sys_wait: got %b exp 0", sys_ready); end
      tick();
      ex_valid = 1'b0; issue_inc = 1'b0;
      checks++; if (flags_q !== 32'h881) begin errors++; $display("FAIL col_ex_first: got %h exp %h", flags_q, 32'h881); end
      tick(); tick();
      checks++; if (sys_ready !== 1'b1) begin errors++; $display("FAIL col_sys_grant: got %b exp 1", sys_ready); end
      tick();
      sys_valid = 1'b0;
      checks++; if (flags_q !== 32'hC81) begin errors++; $display("FAIL col_sys_applied: got %h exp %h", flags_q, 32'hC81); end
   endtask

   task automatic test_saturation();
      issue_inc = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL sat_issue_ready: got %b exp 0", issue_ready); end
      checks++; if (pend_err !== 1'b0) begin errors++; $display("FAIL sat_err_before: got %b exp 0", pend_err); end
      tick();
      issue_inc = 1'b0;
      checks++; if (pend_err !== 1'b1) begin errors++; $display("FAIL sat_err_after: got %b exp 1", pend_err); end
      ex_valid = 1'b1; ex_mask = 12'h000;
      #1;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL sat_ready_with_ex: got %b exp 1", issue_ready); end
      for (int i = 0; i < 6; i++) tick();
      checks++; if (flags_stall !== 1'b1) begin errors++; $display("FAIL sat_pend1: got %b exp 1", flags_stall); end
      tick();
      ex_valid = 1'b0;
      checks++; if (flags_stall !== 1'b0) begin errors++; $display("FAIL sat_pend0: got %b exp 0", flags_stall); end
   endtask

   task automatic test_underflow();
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      checks++; if (pend_err !== 1'b0) begin errors++; $display("FAIL uf_reset_err: got %b exp 0", pend_err); end
      checks++; if (flags_q !== 32'h0) begin errors++; $display("FAIL uf_reset_flags: got %h exp %h", flags_q, 32'h0); end
      ex_valid = 1'b1; ex_flags = 32'h4; ex_mask = 12'h004;
      tick();
      ex_valid = 1'b0;
      checks++; if (flags_q !== 32'h4) begin errors++; $display("FAIL uf_flags: got %h exp %h", flags_q, 32'h4); end
      checks++; if (pend_err !== 1'b1) begin errors++; $display("FAIL uf_err: got %b exp 1", pend_err); end
      checks++; if (flags_stall !== 1'b0) begin errors++; $display("FAIL uf_stall: got %b exp 0", flags_stall); end
      issue_inc = 1'b1; tick(); issue_inc = 1'b0;
      checks++; if (flags_stall !== 1'b1) begin errors++; $display("FAIL uf_inc: got %b exp 1", flags_stall); end
      ex_valid = 1'b1; ex_mask = 12'h000; tick(); ex_valid = 1'b0;
      checks++; if (flags_stall !== 1'b0) begin errors++; $display("FAIL uf_held0: got %b exp 0", flags_stall); end
   endtask

   initial begin
      test_reset();
      test_ex_mask();
      test_serialise();
      test_sys_latency();
      test_collision();
      test_saturation();
      test_underflow();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/eflags_wb_ctrl.md
# eflags_wb_ctrl

Architectural EFLAGS register and its write-back controller, sitting at the tail of the execution core after the flag-generation logic (OF/PF/ZF and the flag-assembly layout). Arbitrates flag updates between the EX write-back port and a serialising system port (CLD/STD/POPF-style microcode writes), and applies per-flag write masks. Tracks in-flight flag writers in a pending counter so decode can stall flag consumers.

## Interface
Parameters:
- PEND_W, 3, width of the pending-writer counter; max outstanding writers = 2^PEND_W − 1.
- RESET_FLAGS, 32'h0000_0000, value loaded into the flag register on reset.

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset, synchronous and active-low
- issue_inc  in  1  decode issues one flag-writing instruction
- issue_ready  out  1  counter can accept issue_inc this cycle
- ex_valid  in  1  EX flag update present
- ex_ready  out  1  EX update accepted when ex_valid & ex_ready
- ex_flags  in  32  new flags, assign_flags layout (CF0 PF2 AF4 ZF6 SF7 DF10 OF11)
- ex_mask  in  12  per-bit write enable, same bit positions
- sys_valid  in  1  system-port write request
- sys_ready  out  1  system write accepted
- sys_flags  in  32  new flags, same layout
- sys_mask  in  12  per-bit write enable
- flags_q  out  32  architectural EFLAGS
- flags_stall  out  1  pending writers exist (pend_cnt ≠ 0)
- pend_err  out  1  sticky: underflow or overflow of pend_cnt

## Operation
- Writable bits: WR_MASK = 12'hCD5. Effective mask = port mask & WR_MASK; flags_q[31:12] and reserved bits 1,3,5,8,9 are always 0.
- Merge: next = (flags_q & ~m) | (port_flags & m), m zero-extended to 32 bits.
- FSM states: RUN, DRAIN, SYS_WR.
  - RUN: ex_ready=1. If sys_valid and no EX transfer this cycle → DRAIN.
  - DRAIN: ex_ready=1 (drains in-flight writers); issue_ready=0. When pend_cnt==0 and no EX transfer this cycle → SYS_WR.
  - SYS_WR: ex_ready=0, issue_ready=0, sys_ready=1 for exactly this cycle; sys merge applied; → RUN.
- EX transfer always wins over sys in the same cycle; sys is never granted while pend_cnt≠0.
- pend_cnt: +1 on accepted issue_inc (issue_inc & issue_ready), −1 on EX transfer; both in same cycle → unchanged.
- issue_ready = (state==RUN) & (pend_cnt ≠ max) | (EX transfer this cycle & state==RUN).
- Underflow (EX transfer with pend_cnt==0, no inc) → counter holds 0, pend_err set. issue_inc while issue_ready=0 → ignored, pend_err set. pend_err clears only on reset.
- sys_valid dropped while in DRAIN → return to RUN, no write.

## Timing
- Reset (rst_n=0 at a clk edge): flags_q=RESET_FLAGS & writable bits, pend_cnt=0, state=RUN, pend_err=0; outputs then: ex_ready=1, sys_ready=0, issue_ready=1, flags_stall=0.
- Reset asserted mid-DRAIN/SYS_WR aborts the request; no partial write.
- EX or sys update visible on flags_q one cycle after the accepting edge.
- flags_stall registered from pend_cnt: reflects counter after the edge, no combinational path from ex_valid.
- Minimum sys latency: sys_valid in RUN with pend_cnt=0 → DRAIN → SYS_WR: sys_ready asserted in 2nd cycle.
- All outputs except ex_ready/sys_ready/issue_ready are registered; those three depend only on state, pend_cnt and ex_valid.

## Structure
- Shared package eflags_pkg: bit-position constants (CF_BIT…OF_BIT), WR_MASK, state encoding.
- Sub-module eflags_merge: combinational masked merge (old, new, mask → next), instantiated once per port; final 2:1 select by grant.
- Counter and FSM live in the top module.

## Test plan
- Reset: hold rst_n=0 two cycles with ex_valid=1 → flags_q=0, pend_cnt=0, no update applied.
- EX masked write: flags_q=0, ex_flags=32'hFFFF_FFFF, ex_mask=12'h0C1 → flags_q=32'h0000_00C1 next cycle (CF,ZF,SF only).
- Serialisation: 2 issue_inc, sys_valid asserted → sys_ready stays 0 until two EX transfers drain pend_cnt to 0, then sys_ready=1 one cycle later; sys_mask=12'h400, DF=1 → flags_q[10]=1.
- Same-cycle collision: issue_inc and EX transfer together at pend_cnt=3 → pend_cnt stays 3; EX and sys both valid in RUN → EX applied, sys waits.
- Counter saturation: PEND_W=3, 7 issues → issue_ready=0, 8th issue_inc ignored, pend_err=1.
- Underflow: EX transfer at pend_cnt=0 → pend_cnt=0, pend_err=1, flags still updated.
